// File: rtl/lock_attempt_ctrl.sv
// rtl/lock_attempt_ctrl.sv - serial password lock front end: constant-time code check, failure lockout, re-keying.
// Optional auto-relock timer in OPEN is built when AUTO_RELOCK_EN is defined.
module lock_attempt_ctrl #(
  parameter int                CODE_W       = 16,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(16'd5938),
  parameter int                MAX_FAIL     = 3,
  parameter int                LOCKOUT_CYC  = 64,
  parameter int                RELOCK_CYC   = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CODE_W-1:0]             code_in,
  input  logic                          code_valid,
  output logic                          code_ready,
  input  logic                          new_code_valid,
  input  logic                          relock,
  output logic                          out,
  output logic                          out_buzz,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic [2:0]                    state
);

  localparam int FC_W  = $clog2(MAX_FAIL + 1);
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int LT_W  = $clog2(LOCKOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_FAIL    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] stored_q, stored_d;
  logic [CODE_W-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mism_q, mism_d;
  logic [FC_W-1:0]   fail_q, fail_d;
  logic [LT_W-1:0]   lt_q, lt_d;
`ifdef AUTO_RELOCK_EN
  localparam int RT_W = $clog2(RELOCK_CYC + 1);
  logic [RT_W-1:0]   rt_q, rt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stored_q <= DEFAULT_CODE;
      cap_q    <= '0;
      idx_q    <= '0;
      mism_q   <= 1'b0;
      fail_q   <= '0;
      lt_q     <= '0;
`ifdef AUTO_RELOCK_EN
      rt_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      stored_q <= stored_d;
      cap_q    <= cap_d;
      idx_q    <= idx_d;
      mism_q   <= mism_d;
      fail_q   <= fail_d;
      lt_q     <= lt_d;
`ifdef AUTO_RELOCK_EN
      rt_q     <= rt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    stored_d = stored_q;
    cap_d    = cap_q;
    idx_d    = idx_q;
    mism_d   = mism_q;
    fail_d   = fail_q;
    lt_d     = lt_q;
`ifdef AUTO_RELOCK_EN
    rt_d     = rt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (code_valid) begin
          cap_d   = code_in;
          idx_d   = IDX_W'(CODE_W - 1);
          mism_d  = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Every bit is visited regardless of an earlier mismatch so timing leaks nothing.
        mism_d = mism_q | (cap_q[idx_q] ^ stored_q[idx_q]);
        idx_d  = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          if (!mism_d) begin
            state_d = S_OPEN;
            fail_d  = '0;
`ifdef AUTO_RELOCK_EN
            rt_d    = '0;
`endif
          end else if (fail_q >= FC_W'(MAX_FAIL - 1)) begin
            state_d = S_LOCKOUT;
            fail_d  = FC_W'(MAX_FAIL);
            lt_d    = '0;
          end else begin
            state_d = S_FAIL;
            fail_d  = fail_q + FC_W'(1);
          end
        end
      end
      S_FAIL: state_d = S_IDLE;
      S_LOCKOUT: begin
        if (lt_q == LT_W'(LOCKOUT_CYC - 1)) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          lt_d = lt_q + LT_W'(1);
        end
      end
      S_OPEN: begin
        if (new_code_valid) stored_d = code_in;
        if (relock) state_d = S_IDLE;
`ifdef AUTO_RELOCK_EN
        if (new_code_valid) begin
          rt_d = '0;
        end else if (rt_q == RT_W'(RELOCK_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          rt_d = rt_q + RT_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    code_ready = (state_q == S_IDLE) && !rst;
    out        = (state_q != S_OPEN) || rst;
    out_buzz   = ((state_q == S_FAIL) || (state_q == S_LOCKOUT)) && !rst;
  end

  assign fail_cnt = fail_q;
  assign state    = state_q;

endmodule
